// File: rtl/tmds_pkg.sv
// Shared types, fixed TMDS code words and small helpers for the TMDS encoder.
package tmds_pkg;

    typedef enum logic [1:0] {
        TMDS_CTRL   = 2'b00,
        TMDS_VIDEO  = 2'b01,
        TMDS_GUARD  = 2'b10,
        TMDS_ISLAND = 2'b11
    } tmds_mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        unique case (c)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] a);
        logic [9:0] s;
        unique case (a)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_encoder_nch_if.sv
// Pixel-side bundle of the multi-lane TMDS encoder: strobe, mode, lane payloads and encoded outputs.
interface tmds_encoder_nch_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
);
    logic                    i_ce;
    logic [1:0]              i_mode;
    logic [8*NUM_CH-1:0]     i_data;
    logic [2*NUM_CH-1:0]     i_ctrl;
    logic [4*NUM_CH-1:0]     i_aux;
    logic [10*NUM_CH-1:0]    o_tmds;
    logic                    o_valid;
    logic [CNT_W*NUM_CH-1:0] o_disp;

    modport master (
        output i_ce, i_mode, i_data, i_ctrl, i_aux,
        input  o_tmds, o_valid, o_disp
    );

    modport slave (
        input  i_ce, i_mode, i_data, i_ctrl, i_aux,
        output o_tmds, o_valid, o_disp
    );
endinterface

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: stage 1 transition-minimises the byte, stage 2 applies
// DC balancing or the fixed code word for the period and keeps the running disparity.
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int LANE     = 0,
    parameter bit EN_TERC4 = 1'b1,
    parameter int CNT_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    adv,
    input  tmds_mode_e              mode,
    input  logic [7:0]              data,
    input  logic [1:0]              ctrl,
    input  logic [3:0]              aux,
    output logic [9:0]              tmds,
    output logic signed [CNT_W-1:0] disp
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    logic [3:0]              n1;
    logic                    use_xnor;
    logic [8:0]              qm;
    tmds_mode_e              s1_mode;
    logic [1:0]              s1_ctrl;
    logic [3:0]              s1_aux;
    logic [8:0]              s1_qm;
    logic [3:0]              s1_n1;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] bal;
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic [9:0]              nxt_sym;
    logic signed [CNT_W-1:0] nxt_cnt;

    // Transition-minimising chain: XNOR for bytes heavy in ones, XOR otherwise.
    always_comb begin
        n1       = popcount8(data);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
        qm       = '0;
        qm[0]    = data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
        end
        qm[8] = ~use_xnor;
    end

    // Stage 1 register: period type, side-band payloads and intermediate word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_mode <= TMDS_CTRL;
            s1_ctrl <= '0;
            s1_aux  <= '0;
            s1_qm   <= '0;
            s1_n1   <= '0;
        end else if (ce) begin
            s1_mode <= mode;
            s1_ctrl <= ctrl;
            s1_aux  <= aux;
            s1_qm   <= qm;
            s1_n1   <= popcount8(qm[7:0]);
        end
    end

    // Stage 2 symbol selection; bal is N1q-N0q, non-video periods restart the disparity at zero.
    always_comb begin
        nxt_sym = tmds;
        nxt_cnt = '0;
        bal     = CNT_W'({s1_n1, 1'b0}) - CNT_W'(5'd8);
        cnt_neg = cnt[CNT_W-1];
        cnt_pos = !cnt[CNT_W-1] && (cnt != '0);
        unique case (s1_mode)
            TMDS_VIDEO: begin
                if ((cnt == '0) || (s1_n1 == 4'd4)) begin
                    nxt_sym = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                    nxt_cnt = s1_qm[8] ? cnt + bal : cnt - bal;
                end else if ((cnt_pos && (s1_n1 > 4'd4)) || (cnt_neg && (s1_n1 < 4'd4))) begin
                    nxt_sym = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                    nxt_cnt = cnt - bal + (s1_qm[8] ? TWO : '0);
                end else begin
                    nxt_sym = {1'b0, s1_qm[8], s1_qm[7:0]};
                    nxt_cnt = cnt + bal - (s1_qm[8] ? '0 : TWO);
                end
            end
            TMDS_GUARD:  nxt_sym = (LANE == 1) ? GUARD_B : GUARD_A;
            TMDS_ISLAND: nxt_sym = EN_TERC4 ? terc4_code(s1_aux) : ctrl_code(s1_ctrl);
            default:     nxt_sym = ctrl_code(s1_ctrl);
        endcase
    end

    // Stage 2 register: advances only once stage 1 holds a real sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmds <= '0;
            cnt  <= '0;
        end else if (ce && adv) begin
            tmds <= nxt_sym;
            cnt  <= nxt_cnt;
        end
    end

    assign disp = cnt;

endmodule

// File: rtl/tmds_encoder_nch.sv
// Multi-lane pipelined TMDS encoder; lanes share the strobe, mode and valid tracking.
module tmds_encoder_nch
    import tmds_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter bit EN_TERC4 = 1'b1,
    parameter int CNT_W    = 5
) (
    input logic               i_clk,
    input logic               i_rst,
    tmds_encoder_nch_if.slave bus
);

    logic [1:0]              vld_sr;
    tmds_mode_e              mode;
    logic [10*NUM_CH-1:0]    tmds_all;
    logic [CNT_W*NUM_CH-1:0] disp_all;

    assign mode = tmds_mode_e'(bus.i_mode);

    // Valid shifter: bit 0 marks stage 1 loaded, bit 1 pulses on each strobe that updates the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_sr <= '0;
        end else if (bus.i_ce) begin
            vld_sr <= {vld_sr[0], 1'b1};
        end else begin
            vld_sr[1] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        tmds_lane_enc #(
            .LANE     (k),
            .EN_TERC4 (EN_TERC4),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk  (i_clk),
            .rst  (i_rst),
            .ce   (bus.i_ce),
            .adv  (vld_sr[0]),
            .mode (mode),
            .data (bus.i_data[8*k +: 8]),
            .ctrl (bus.i_ctrl[2*k +: 2]),
            .aux  (bus.i_aux[4*k +: 4]),
            .tmds (tmds_all[10*k +: 10]),
            .disp (disp_all[CNT_W*k +: CNT_W])
        );
    end

    assign bus.o_tmds  = tmds_all;
    assign bus.o_disp  = disp_all;
    assign bus.o_valid = vld_sr[1];

endmodule

// File: tb/tb_tmds_encoder_nch.sv
// Directed-vector and model-comparison bench for the 3-lane TMDS encoder.
module tb_tmds_encoder_nch;

    localparam int NCH = 3;
    localparam int CW  = 5;
    localparam int NV  = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_encoder_nch_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();
    tmds_encoder_nch_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_nt ();

    assign bus_nt.i_ce   = bus.i_ce;
    assign bus_nt.i_mode = bus.i_mode;
    assign bus_nt.i_data = bus.i_data;
    assign bus_nt.i_ctrl = bus.i_ctrl;
    assign bus_nt.i_aux  = bus.i_aux;

    tmds_encoder_nch #(.NUM_CH(NCH), .EN_TERC4(1'b1), .CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    tmds_encoder_nch #(.NUM_CH(NCH), .EN_TERC4(1'b0), .CNT_W(CW)) dut_nt (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_nt)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] aux;
        logic [29:0] exp_tmds;
        logic [14:0] exp_disp;
    } vec_t;

    typedef struct {
        logic [9:0] sym;
        int         cnt;
    } enc_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] ref_terc4(input logic [3:0] a);
        case (a)
            4'd0:    return 10'b1010011100;
            4'd1:    return 10'b1001100011;
            4'd2:    return 10'b1011100100;
            4'd3:    return 10'b1011100010;
            4'd4:    return 10'b0101110001;
            4'd5:    return 10'b0100011110;
            4'd6:    return 10'b0110001110;
            4'd7:    return 10'b0100111100;
            4'd8:    return 10'b1011001100;
            4'd9:    return 10'b0100111001;
            4'd10:   return 10'b0110011100;
            4'd11:   return 10'b1011000110;
            4'd12:   return 10'b1010001110;
            4'd13:   return 10'b1001110001;
            4'd14:   return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    function automatic enc_t ref_lane(input int lane, input logic [1:0] mode, input logic [7:0] d,
                                      input logic [1:0] c, input logic [3:0] a, input int cnt_in);
        enc_t r;
        int n1, ones, zeros;
        bit use_xnor, q8;
        logic [7:0] q;
        r.cnt = 0;
        case (mode)
            2'b01: begin
                n1 = 0;
                for (int i = 0; i < 8; i++) n1 += int'(d[i]);
                use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
                q[0] = d[0];
                for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
                q8 = !use_xnor;
                ones = 0;
                for (int i = 0; i < 8; i++) ones += int'(q[i]);
                zeros = 8 - ones;
                if (cnt_in == 0 || ones == zeros) begin
                    r.sym = {!q8, q8, q8 ? q : ~q};
                    r.cnt = cnt_in + (q8 ? (ones - zeros) : (zeros - ones));
                end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
                    r.sym = {1'b1, q8, ~q};
                    r.cnt = cnt_in + 2 * int'(q8) + (zeros - ones);
                end else begin
                    r.sym = {1'b0, q8, q};
                    r.cnt = cnt_in - 2 * int'(!q8) + (ones - zeros);
                end
            end
            2'b10:   r.sym = (lane == 1) ? 10'b0100110011 : 10'b1011001100;
            2'b11:   r.sym = ref_terc4(a);
            default: r.sym = ref_ctrl(c);
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                                input logic [9:0] s, input logic [4:0] dp);
        vec_t v;
        v.mode     = m;
        v.data     = {d, d, d};
        v.ctrl     = {c, c, c};
        v.aux      = '0;
        v.exp_tmds = {s, s, s};
        v.exp_disp = {dp, dp, dp};
        return v;
    endfunction

    task automatic drive(input logic ce, input logic [1:0] m, input logic [23:0] d,
                         input logic [5:0] c, input logic [11:0] a);
        bus.i_ce   = ce;
        bus.i_mode = m;
        bus.i_data = d;
        bus.i_ctrl = c;
        bus.i_aux  = a;
    endtask

    // model state for the random stream
    logic [1:0]  p1_mode;
    logic [23:0] p1_data;
    logic [5:0]  p1_ctrl;
    logic [11:0] p1_aux;
    bit          p1_valid;
    int          m_cnt[NCH];
    logic [29:0] m_tmds;
    logic [14:0] m_disp;
    bit          m_valid;

    initial begin
        logic [29:0] held_tmds;
        logic [14:0] held_disp;
        logic [1:0]  rm;
        logic [23:0] rd;
        logic [5:0]  rc;
        logic [11:0] ra;
        logic        rce;
        enc_t        e;

        drive(1'b0, 2'b00, '0, '0, '0);

        vecs[0]  = mk(2'b00, 8'h00, 2'b00, 10'b1101010100, 5'b00000);
        vecs[1]  = mk(2'b01, 8'h00, 2'b00, 10'b0100000000, 5'b11000);
        vecs[2]  = mk(2'b01, 8'h00, 2'b00, 10'b1111111111, 5'b00010);
        vecs[3]  = mk(2'b01, 8'h00, 2'b00, 10'b0100000000, 5'b11010);
        vecs[4]  = mk(2'b00, 8'h00, 2'b01, 10'b0010101011, 5'b00000);
        vecs[5]  = mk(2'b01, 8'h0F, 2'b00, 10'b0100000101, 5'b11100);
        vecs[6]  = mk(2'b01, 8'hFF, 2'b00, 10'b0011111111, 5'b00010);
        vecs[7]  = mk(2'b01, 8'hFF, 2'b00, 10'b1000000000, 5'b11010);
        vecs[8]  = mk(2'b10, 8'h00, 2'b00, 10'b0, 5'b00000);
        vecs[8].exp_tmds = {10'b1011001100, 10'b0100110011, 10'b1011001100};
        vecs[9]  = mk(2'b01, 8'h00, 2'b00, 10'b0100000000, 5'b11000);
        vecs[10] = mk(2'b00, 8'h00, 2'b10, 10'b0101010100, 5'b00000);
        vecs[11] = mk(2'b00, 8'h00, 2'b11, 10'b1010101011, 5'b00000);
        vecs[12] = mk(2'b11, 8'h00, 2'b00, 10'b0, 5'b00000);
        vecs[12].aux      = {4'hF, 4'h5, 4'h0};
        vecs[12].exp_tmds = {10'b1011000011, 10'b0100011110, 10'b1010011100};

        // reset state
        tick();
        tick();
        check("reset_tmds", 64'(bus.o_tmds), 64'd0);
        check("reset_valid", 64'(bus.o_valid), 64'd0);
        check("reset_disp", 64'(bus.o_disp), 64'd0);
        rst = 1'b0;

        // first-symbol latency
        drive(1'b1, 2'b00, '0, 6'b000000, '0);
        tick();
        check("lat_edge1_tmds", 64'(bus.o_tmds), 64'd0);
        check("lat_edge1_valid", 64'(bus.o_valid), 64'd0);
        tick();
        check("lat_edge2_lane0", 64'(bus.o_tmds[9:0]), 64'(10'b1101010100));
        check("lat_edge2_valid", 64'(bus.o_valid), 64'd1);

        // asynchronous reset between edges
        drive(1'b1, 2'b01, 24'h123456, '0, '0);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_tmds", 64'(bus.o_tmds), 64'd0);
        check("async_rst_valid", 64'(bus.o_valid), 64'd0);
        check("async_rst_disp", 64'(bus.o_disp), 64'd0);
        tick();
        rst = 1'b0;

        // directed table, streamed back-to-back
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(1'b1, vecs[i].mode, vecs[i].data, vecs[i].ctrl, vecs[i].aux);
            tick();
            if (i > 0) begin
                check($sformatf("vec%0d_tmds", i - 1), 64'(bus.o_tmds), 64'(vecs[i-1].exp_tmds));
                check($sformatf("vec%0d_disp", i - 1), 64'(bus.o_disp), 64'(vecs[i-1].exp_disp));
                check($sformatf("vec%0d_valid", i - 1), 64'(bus.o_valid), 64'd1);
            end
        end

        // full TERC4 sweep; the instance without data islands falls back to control codes
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] nib;
            nib = 4'(k);
            if (k < 16) drive(1'b1, 2'b11, '0, 6'b111111, {nib, nib, nib});
            tick();
            if (k > 0) begin
                logic [9:0] t;
                t = ref_terc4(4'(k - 1));
                check($sformatf("terc4_%0d", k - 1), 64'(bus.o_tmds), 64'({t, t, t}));
                check($sformatf("noterc4_%0d", k - 1), 64'(bus_nt.o_tmds),
                      64'({10'b1010101011, 10'b1010101011, 10'b1010101011}));
            end
        end

        // strobe gating: outputs and disparity frozen while i_ce is low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 24'($urandom), '0, '0);
            tick();
        end
        held_tmds = bus.o_tmds;
        held_disp = bus.o_disp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b01, 24'($urandom), '0, '0);
            tick();
            check($sformatf("ce_low%0d_tmds", i), 64'(bus.o_tmds), 64'(held_tmds));
            check($sformatf("ce_low%0d_disp", i), 64'(bus.o_disp), 64'(held_disp));
            check($sformatf("ce_low%0d_valid", i), 64'(bus.o_valid), 64'd0);
        end
        drive(1'b1, 2'b01, 24'($urandom), '0, '0);
        tick();
        check("ce_resume_valid", 64'(bus.o_valid), 64'd1);

        // long random stream against the behavioural model
        rst = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0);
        tick();
        rst = 1'b0;
        p1_valid = 1'b0;
        p1_mode = '0; p1_data = '0; p1_ctrl = '0; p1_aux = '0;
        m_tmds = '0; m_disp = '0; m_valid = 1'b0;
        for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
        for (int n = 0; n < 10000; n++) begin
            int sel;
            rce = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            rm  = (sel < 6) ? 2'b01 : (sel == 7) ? 2'b10 : (sel == 8) ? 2'b11 : 2'b00;
            rd  = 24'($urandom);
            rc  = 6'($urandom);
            ra  = 12'($urandom);
            drive(rce, rm, rd, rc, ra);
            tick();
            if (rce) begin
                if (p1_valid) begin
                    for (int k = 0; k < NCH; k++) begin
                        e = ref_lane(k, p1_mode, p1_data[8*k +: 8], p1_ctrl[2*k +: 2],
                                     p1_aux[4*k +: 4], m_cnt[k]);
                        m_cnt[k] = e.cnt;
                        m_tmds[10*k +: 10] = e.sym;
                        m_disp[CW*k +: CW] = 5'(e.cnt);
                    end
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                p1_mode = rm; p1_data = rd; p1_ctrl = rc; p1_aux = ra;
                p1_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            check($sformatf("rand%0d", n), 64'({bus.o_valid, bus.o_disp, bus.o_tmds}),
                  64'({m_valid, m_disp, m_tmds}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
